// File: rtl/phy_wb_arbiter.sv
// Writeback arbiter: per-execution-unit result FIFOs drained round-robin
// into WB_WIDTH registered physical register file write lanes.
module phy_wb_arbiter #(
    parameter int EXU_NUM          = 4,
    parameter int WB_WIDTH         = 2,
    parameter int PHY_REG_ID_WIDTH = 7,
    parameter int REG_DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH       = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        exu_wb_valid     [EXU_NUM],
    output logic                        exu_wb_ready     [EXU_NUM],
    input  logic                        exu_wb_rd_enable [EXU_NUM],
    input  logic [PHY_REG_ID_WIDTH-1:0] exu_wb_id        [EXU_NUM],
    input  logic [REG_DATA_WIDTH-1:0]   exu_wb_data      [EXU_NUM],
    input  logic                        commit_wb_flush,
    output logic [PHY_REG_ID_WIDTH-1:0] wb_phyf_id       [WB_WIDTH],
    output logic [REG_DATA_WIDTH-1:0]   wb_phyf_data     [WB_WIDTH],
    output logic [WB_WIDTH-1:0]         wb_phyf_we
);

    localparam int SRC_W = (EXU_NUM > 1) ? $clog2(EXU_NUM) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [PHY_REG_ID_WIDTH-1:0] id_mem   [EXU_NUM][FIFO_DEPTH];
    logic [REG_DATA_WIDTH-1:0]   data_mem [EXU_NUM][FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr   [EXU_NUM];
    logic [PTR_W-1:0]            rd_ptr   [EXU_NUM];
    logic [CNT_W-1:0]            count    [EXU_NUM];
    logic [EXU_NUM-1:0]          push;
    logic [EXU_NUM-1:0]          pop;
    logic [SRC_W-1:0]            rr;
    logic [SRC_W-1:0]            rr_nxt;
    logic [SRC_W-1:0]            idx;
    int unsigned                 n_grant;
    logic [WB_WIDTH-1:0]         lane_vld;
    logic [SRC_W-1:0]            lane_src [WB_WIDTH];

    // Ready ignores a same-cycle pop, so a full FIFO never accepts.
    always_comb begin
        for (int unsigned i = 0; i < EXU_NUM; i++) begin
            exu_wb_ready[i] = (count[i] < CNT_W'(FIFO_DEPTH)) & ~commit_wb_flush & rst;
            push[i]         = exu_wb_valid[i] & exu_wb_ready[i] & exu_wb_rd_enable[i];
        end
    end

    // Scan from rr, granting non-empty FIFOs to lanes in scan order.
    always_comb begin
        pop      = '0;
        lane_vld = '0;
        rr_nxt   = rr;
        idx      = rr;
        n_grant  = 0;
        for (int unsigned l = 0; l < WB_WIDTH; l++) lane_src[l] = '0;
        for (int unsigned k = 0; k < EXU_NUM; k++) begin
            if (count[idx] != '0 && n_grant < WB_WIDTH) begin
                pop[idx] = 1'b1;
                for (int unsigned l = 0; l < WB_WIDTH; l++) begin
                    if (l == n_grant) begin
                        lane_vld[l] = 1'b1;
                        lane_src[l] = idx;
                    end
                end
                n_grant = n_grant + 1;
                rr_nxt  = (idx == SRC_W'(EXU_NUM - 1)) ? '0 : idx + SRC_W'(1);
            end
            idx = (idx == SRC_W'(EXU_NUM - 1)) ? '0 : idx + SRC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || commit_wb_flush) begin
            for (int unsigned i = 0; i < EXU_NUM; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr         <= '0;
            wb_phyf_we <= '0;
        end else begin
            for (int unsigned i = 0; i < EXU_NUM; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                if (push[i] && !pop[i])      count[i] <= count[i] + CNT_W'(1);
                else if (pop[i] && !push[i]) count[i] <= count[i] - CNT_W'(1);
            end
            rr         <= rr_nxt;
            wb_phyf_we <= lane_vld;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < EXU_NUM; i++) begin
            if (push[i]) begin
                id_mem[i][wr_ptr[i]]   <= exu_wb_id[i];
                data_mem[i][wr_ptr[i]] <= exu_wb_data[i];
            end
        end
    end

    // Idle lanes keep their last id/data; only we marks a real write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned l = 0; l < WB_WIDTH; l++) begin
                wb_phyf_id[l]   <= '0;
                wb_phyf_data[l] <= '0;
            end
        end else if (!commit_wb_flush) begin
            for (int unsigned l = 0; l < WB_WIDTH; l++) begin
                if (lane_vld[l]) begin
                    wb_phyf_id[l]   <= id_mem[lane_src[l]][rd_ptr[lane_src[l]]];
                    wb_phyf_data[l] <= data_mem[lane_src[l]][rd_ptr[lane_src[l]]];
                end
            end
        end
    end

endmodule

// File: tb/tb_phy_wb_arbiter.sv
// Directed bench for phy_wb_arbiter with a per-source ordering scoreboard.
module tb_phy_wb_arbiter;

    localparam int EN = 4;
    localparam int WB = 2;
    localparam int IW = 7;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          exu_wb_valid     [EN];
    logic          exu_wb_ready     [EN];
    logic          exu_wb_rd_enable [EN];
    logic [IW-1:0] exu_wb_id        [EN];
    logic [DW-1:0] exu_wb_data      [EN];
    logic          commit_wb_flush;
    logic [IW-1:0] wb_phyf_id       [WB];
    logic [DW-1:0] wb_phyf_data     [WB];
    logic [WB-1:0] wb_phyf_we;

    int n_total = 0;
    int n_bad   = 0;
    logic [IW+DW-1:0] sbq [EN][$];
    logic             xfer [EN];
    int               s [3];

    phy_wb_arbiter #(
        .EXU_NUM(EN), .WB_WIDTH(WB), .PHY_REG_ID_WIDTH(IW),
        .REG_DATA_WIDTH(DW), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .exu_wb_valid(exu_wb_valid), .exu_wb_ready(exu_wb_ready),
        .exu_wb_rd_enable(exu_wb_rd_enable), .exu_wb_id(exu_wb_id),
        .exu_wb_data(exu_wb_data), .commit_wb_flush(commit_wb_flush),
        .wb_phyf_id(wb_phyf_id), .wb_phyf_data(wb_phyf_data),
        .wb_phyf_we(wb_phyf_we)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < EN; i++) begin
            exu_wb_valid[i]     = 1'b0;
            exu_wb_rd_enable[i] = 1'b0;
            exu_wb_id[i]        = '0;
            exu_wb_data[i]      = '0;
        end
    endtask

    // Record accepted results shortly after inputs settle; flush/reset drop them.
    always @(negedge clk) begin
        #1;
        for (int i = 0; i < EN; i++) begin
            xfer[i] = exu_wb_valid[i] & exu_wb_ready[i];
            if (xfer[i] && exu_wb_rd_enable[i])
                sbq[i].push_back({exu_wb_id[i], exu_wb_data[i]});
        end
        if (!rst || commit_wb_flush)
            for (int i = 0; i < EN; i++) sbq[i].delete();
    end

    // Every write must match the head of exactly one source queue.
    always @(negedge clk) begin
        for (int l = 0; l < WB; l++) begin
            if (rst === 1'b1 && wb_phyf_we[l] === 1'b1) begin
                int found;
                found = 0;
                for (int i = 0; i < EN; i++) begin
                    if (found == 0 && sbq[i].size() > 0 && sbq[i][0][IW+DW-1:DW] == wb_phyf_id[l]) begin
                        found = 1;
                        check("sb_data", wb_phyf_data[l], sbq[i][0][DW-1:0]);
                        void'(sbq[i].pop_front());
                    end
                end
                check("sb_known_id", found, 1);
            end
        end
    end

    initial begin
        rst             = 1'b0;
        commit_wb_flush = 1'b0;
        idle_inputs();
        for (int i = 0; i < EN; i++) begin
            xfer[i]         = 1'b0;
            exu_wb_valid[i] = 1'b1;
        end

        // Reset held for two edges with valid asserted
        cyc(); cyc();
        check("rst_we", wb_phyf_we, 0);
        for (int l = 0; l < WB; l++) begin
            check("rst_id", wb_phyf_id[l], 0);
            check("rst_data", wb_phyf_data[l], 0);
        end
        for (int i = 0; i < EN; i++) check("rst_ready", exu_wb_ready[i], 0);
        rst = 1'b1;
        idle_inputs();
        #2;
        for (int i = 0; i < EN; i++) check("rel_ready", exu_wb_ready[i], 1);

        // Round-robin: four sources push ids 1..4 together
        cyc();
        for (int i = 0; i < EN; i++) begin
            exu_wb_valid[i]     = 1'b1;
            exu_wb_rd_enable[i] = 1'b1;
            exu_wb_id[i]        = IW'(i + 1);
            exu_wb_data[i]      = 32'hA000_0000 + 32'(i);
        end
        cyc();
        idle_inputs();
        check("rr_we_t1", wb_phyf_we, 0);
        cyc();
        check("rr_we_a", wb_phyf_we, 2'b11);
        check("rr_id0_a", wb_phyf_id[0], 1);
        check("rr_id1_a", wb_phyf_id[1], 2);
        check("rr_data0_a", wb_phyf_data[0], 32'hA000_0000);
        cyc();
        check("rr_we_b", wb_phyf_we, 2'b11);
        check("rr_id0_b", wb_phyf_id[0], 3);
        check("rr_id1_b", wb_phyf_id[1], 4);
        cyc();
        check("rr_we_c", wb_phyf_we, 0);

        // Single source, lane 0 only
        exu_wb_valid[0]     = 1'b1;
        exu_wb_rd_enable[0] = 1'b1;
        exu_wb_id[0]        = 7'd5;
        exu_wb_data[0]      = 32'h1acd_ef89;
        cyc();
        idle_inputs();
        check("single_we_t1", wb_phyf_we, 0);
        cyc();
        check("single_we", wb_phyf_we, 2'b01);
        check("single_id", wb_phyf_id[0], 5);
        check("single_data", wb_phyf_data[0], 32'h1acd_ef89);
        cyc();
        check("single_we_after", wb_phyf_we, 0);

        // Result without destination is accepted and dropped
        exu_wb_valid[1] = 1'b1;
        exu_wb_id[1]    = 7'd9;
        exu_wb_data[1]  = 32'hDEAD_0009;
        #2;
        check("nodst_ready", exu_wb_ready[1], 1);
        cyc();
        idle_inputs();
        #2;
        check("nodst_ready_after", exu_wb_ready[1], 1);
        cyc();
        check("nodst_we_a", wb_phyf_we, 0);
        cyc();
        check("nodst_we_b", wb_phyf_we, 0);

        // Load all FIFOs, then flush
        for (int i = 0; i < EN; i++) begin
            exu_wb_valid[i]     = 1'b1;
            exu_wb_rd_enable[i] = 1'b1;
            exu_wb_id[i]        = IW'(16 + i);
            exu_wb_data[i]      = 32'hC000_0000 + 32'(i);
        end
        cyc();
        for (int i = 0; i < EN; i++) begin
            exu_wb_id[i]   = IW'(24 + i);
            exu_wb_data[i] = 32'hC100_0000 + 32'(i);
        end
        cyc();
        idle_inputs();
        commit_wb_flush = 1'b1;
        #2;
        for (int i = 0; i < EN; i++) check("flush_ready", exu_wb_ready[i], 0);
        cyc();
        commit_wb_flush = 1'b0;
        check("flush_we_next", wb_phyf_we, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("flush_we_quiet", wb_phyf_we, 0);
        end

        // Post-flush push keeps the normal latency
        exu_wb_valid[3]     = 1'b1;
        exu_wb_rd_enable[3] = 1'b1;
        exu_wb_id[3]        = 7'h33;
        exu_wb_data[3]      = 32'h3333_0001;
        cyc();
        idle_inputs();
        check("pf_we_t1", wb_phyf_we, 0);
        cyc();
        check("pf_we", wb_phyf_we, 2'b01);
        check("pf_id", wb_phyf_id[0], 7'h33);
        cyc();

        // Back-pressure: sources 0,1,2 stream eight results each
        for (int i = 0; i < 3; i++) s[i] = 0;
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (xfer[i]) s[i]++;
                exu_wb_valid[i]     = (s[i] < 8);
                exu_wb_rd_enable[i] = 1'b1;
                exu_wb_id[i]        = IW'(i * 32 + s[i]);
                exu_wb_data[i]      = 32'hB000_0000 + 32'(i * 65536 + s[i]);
            end
            #2;
            if (k < 3) check("bp_ready2", exu_wb_ready[2], (k < 2) ? 1 : 0);
            if (k == 2) begin
                check("bp_we_c2", wb_phyf_we, 2'b11);
                check("bp_src_l0_c2", wb_phyf_id[0][6:5], 0);
                check("bp_src_l1_c2", wb_phyf_id[1][6:5], 1);
            end
            if (k == 3) begin
                check("bp_src_l0_c3", wb_phyf_id[0][6:5], 2);
                check("bp_src_l1_c3", wb_phyf_id[1][6:5], 0);
            end
            cyc();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) check("bp_sent", s[i], 8);
        cyc(); cyc();
        check("end_we", wb_phyf_we, 0);
        for (int i = 0; i < EN; i++) check("sb_drained", sbq[i].size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
